// File: rtl/mcu_isa_pkg.sv
// Shared ISA definitions for the 8-bit MCU: opcode values, instruction length
// decode and the fetch FSM state encoding.
package mcu_isa_pkg;

  localparam int ISA_W = 8;

  localparam logic [ISA_W-1:0] OP_NOP      = 8'h00;
  localparam logic [ISA_W-1:0] OP_BRA      = 8'h20;
  localparam logic [ISA_W-1:0] OP_BMI      = 8'h21;
  localparam logic [ISA_W-1:0] OP_BEQ      = 8'h22;
  localparam logic [ISA_W-1:0] OP_BCS      = 8'h23;
  localparam logic [ISA_W-1:0] OP_ALU_LO   = 8'h40;
  localparam logic [ISA_W-1:0] OP_ALU_HI   = 8'h4F;
  localparam logic [ISA_W-1:0] OP_LDA_IMM  = 8'h86;
  localparam logic [ISA_W-1:0] OP_LDA_DIR  = 8'h87;
  localparam logic [ISA_W-1:0] OP_LDX_IMM  = 8'h88;
  localparam logic [ISA_W-1:0] OP_LDX_DIR  = 8'h89;
  localparam logic [ISA_W-1:0] OP_STAA_DIR = 8'h96;
  localparam logic [ISA_W-1:0] OP_STX_DIR  = 8'h97;

  typedef enum logic [1:0] {
    S_OPCODE,
    S_OPERAND,
    S_HOLD
  } fetch_state_t;

  // Opcodes that are followed by an operand byte.
  function automatic logic is_two_byte(input logic [ISA_W-1:0] op);
    case (op)
      OP_LDA_IMM, OP_LDA_DIR, OP_LDX_IMM, OP_LDX_DIR,
      OP_STAA_DIR, OP_STX_DIR,
      OP_BRA, OP_BMI, OP_BEQ, OP_BCS: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Opcodes present in the length table; anything else traps in execute.
  function automatic logic is_legal(input logic [ISA_W-1:0] op);
    if (is_two_byte(op))
      return 1'b1;
    if (op == OP_NOP)
      return 1'b1;
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Program-memory fetch for the 8-bit MCU. Reads the combinational program ROM
// at the current pc, assembles 1- or 2-byte instructions, folds unconditional
// BRA into the pc, and presents everything else to execute over valid/ready.
module instr_fetch_unit
  import mcu_isa_pkg::*;
#(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_two_byte,
  output logic              instr_illegal,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              valid_r;
  logic [DATA_W-1:0] op_r;
  logic [DATA_W-1:0] operand_r;
  logic              two_byte_r;
  logic              illegal_r;
  logic [ADDR_W-1:0] ipc_r;

  // Branch target relative to the address after the operand byte. The cast
  // sign-extends (or truncates) the displacement to ADDR_W, so the sum wraps
  // modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] bra_target(
    input logic        [ADDR_W-1:0] next_pc,
    input logic signed [DATA_W-1:0] off
  );
    logic [ADDR_W-1:0] off_a;
    off_a = ADDR_W'(off);
    return next_pc + off_a;
  endfunction

  // Sequential pc increment, naturally wrapping at the top of program memory.
  assign pc_inc      = pc + ADDR_W'(1);
  assign rom_address = pc;

  assign instr_valid    = valid_r;
  assign instr_opcode   = op_r;
  assign instr_operand  = operand_r;
  assign instr_two_byte = two_byte_r;
  assign instr_illegal  = illegal_r;
  assign instr_pc       = ipc_r;

  // Fetch FSM: redirect overrides everything; otherwise opcode, optional
  // operand, then hold until execute takes the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_OPCODE;
      pc         <= RESET_PC;
      valid_r    <= 1'b0;
      op_r       <= '0;
      operand_r  <= '0;
      two_byte_r <= 1'b0;
      illegal_r  <= 1'b0;
      ipc_r      <= '0;
    end else if (redirect_valid) begin
      // A held instruction seeing ready in this cycle has already been taken
      // by execute; dropping valid here is all that is needed.
      pc      <= redirect_addr;
      state   <= S_OPCODE;
      valid_r <= 1'b0;
    end else begin
      case (state)
        S_OPCODE: begin
          op_r       <= rom_data;
          ipc_r      <= pc;
          pc         <= pc_inc;
          two_byte_r <= is_two_byte(rom_data[ISA_W-1:0]);
          illegal_r  <= !is_legal(rom_data[ISA_W-1:0]);
          if (is_two_byte(rom_data[ISA_W-1:0])) begin
            state <= S_OPERAND;
          end else begin
            operand_r <= '0;
            valid_r   <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_OPERAND: begin
          operand_r <= rom_data;
          if (op_r[ISA_W-1:0] == OP_BRA) begin
            // Unconditional branch is resolved here and never shown to execute.
            pc    <= bra_target(pc_inc, rom_data);
            state <= S_OPCODE;
          end else begin
            pc      <= pc_inc;
            valid_r <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            valid_r <= 1'b0;
            state   <= S_OPCODE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state   <= S_OPCODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 128x8 program ROM.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [6:0] rom_address;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_two_byte;
  logic       instr_illegal;
  logic [6:0] instr_pc;
  logic       redirect_valid;
  logic [6:0] redirect_addr;

  logic [7:0] rom [128];

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W  (7),
    .DATA_W  (8),
    .RESET_PC(7'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_two_byte(instr_two_byte),
    .instr_illegal (instr_illegal),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  assign rom_data = rom[rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [7:0] op, input logic [7:0] opnd,
                           input logic two, input logic ill, input logic [6:0] ipc);
    chk({tag, ".valid"},    32'(instr_valid),    32'(1'b1));
    chk({tag, ".opcode"},   32'(instr_opcode),   32'(op));
    chk({tag, ".operand"},  32'(instr_operand),  32'(opnd));
    chk({tag, ".two_byte"}, 32'(instr_two_byte), 32'(two));
    chk({tag, ".illegal"},  32'(instr_illegal),  32'(ill));
    chk({tag, ".pc"},       32'(instr_pc),       32'(ipc));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[0]    = 8'h86; rom[1] = 8'hAA;
    rom[2]    = 8'h96; rom[3] = 8'hF0;
    rom[4]    = 8'h20; rom[5] = 8'hFE;
    rom[7'h10] = 8'hFF;
    rom[7'h40] = 8'h42;
    rom[7'h7F] = 8'h42;

    reset          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 7'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid",    32'(instr_valid),    0);
    chk("rst.addr",     32'(rom_address),    0);
    chk("rst.opcode",   32'(instr_opcode),   0);
    chk("rst.operand",  32'(instr_operand),  0);
    chk("rst.two_byte", 32'(instr_two_byte), 0);
    chk("rst.illegal",  32'(instr_illegal),  0);
    chk("rst.pc",       32'(instr_pc),       0);
    reset = 1'b1;

    // Test 1: stream with ready=1, then BRA * loop
    tick();
    chk("t1.c1.valid", 32'(instr_valid), 0);
    chk("t1.c1.addr",  32'(rom_address), 1);
    tick();
    chk_issue("t1.i0", 8'h86, 8'hAA, 1'b1, 1'b0, 7'h00);
    chk("t1.c2.addr", 32'(rom_address), 2);
    tick();
    chk("t1.c3.valid", 32'(instr_valid), 0);
    tick();
    chk("t1.c4.addr", 32'(rom_address), 3);
    tick();
    chk_issue("t1.i1", 8'h96, 8'hF0, 1'b1, 1'b0, 7'h02);
    tick();
    chk("t1.loop0.addr", 32'(rom_address), 4);
    tick();
    chk("t1.loop1.addr", 32'(rom_address), 5);
    chk("t1.loop1.valid", 32'(instr_valid), 0);
    tick();
    chk("t1.loop2.addr", 32'(rom_address), 4);
    chk("t1.loop2.valid", 32'(instr_valid), 0);
    tick();
    chk("t1.loop3.addr", 32'(rom_address), 5);
    chk("t1.loop3.valid", 32'(instr_valid), 0);

    // Test 2: back-pressure for 5 cycles
    instr_ready = 1'b0;
    pulse_reset();
    tick();
    tick();
    chk_issue("t2.i0", 8'h86, 8'hAA, 1'b1, 1'b0, 7'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2.hold.valid",   32'(instr_valid),   1);
      chk("t2.hold.opcode",  32'(instr_opcode),  32'h86);
      chk("t2.hold.operand", 32'(instr_operand), 32'hAA);
      chk("t2.hold.pc",      32'(instr_pc),      0);
      chk("t2.hold.addr",    32'(rom_address),   2);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2.acc.valid", 32'(instr_valid), 0);
    chk("t2.acc.addr",  32'(rom_address), 2);
    tick();
    tick();
    chk_issue("t2.i1", 8'h96, 8'hF0, 1'b1, 1'b0, 7'h02);

    // Test 3: redirect while waiting for an operand
    pulse_reset();
    tick();
    chk("t3.opnd.addr", 32'(rom_address), 1);
    redirect_valid = 1'b1;
    redirect_addr  = 7'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3.redir.valid", 32'(instr_valid), 0);
    chk("t3.redir.addr",  32'(rom_address), 32'h40);
    tick();
    chk_issue("t3.i0", 8'h42, 8'h00, 1'b0, 1'b0, 7'h40);

    // Test 4a: accept + redirect in the same cycle, 1-byte opcode at 0x7F wraps
    redirect_valid = 1'b1;
    redirect_addr  = 7'h7F;
    tick();
    redirect_valid = 1'b0;
    chk("t4a.redir.valid", 32'(instr_valid), 0);
    chk("t4a.redir.addr",  32'(rom_address), 32'h7F);
    tick();
    chk_issue("t4a.i0", 8'h42, 8'h00, 1'b0, 1'b0, 7'h7F);
    chk("t4a.wrap.addr", 32'(rom_address), 0);

    // Test 4b: 2-byte opcode at 0x7F takes its operand from 0x00
    rom[7'h7F]     = 8'h86;
    redirect_valid = 1'b1;
    redirect_addr  = 7'h7F;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t4b.opnd.addr", 32'(rom_address), 0);
    tick();
    chk_issue("t4b.i0", 8'h86, 8'h86, 1'b1, 1'b0, 7'h7F);
    chk("t4b.next.addr", 32'(rom_address), 1);

    // Test 5: illegal opcode
    redirect_valid = 1'b1;
    redirect_addr  = 7'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk_issue("t5.i0", 8'hFF, 8'h00, 1'b0, 1'b1, 7'h10);
    chk("t5.next.addr", 32'(rom_address), 32'h11);

    // Test 6: asynchronous reset while an instruction is held
    #2;
    reset = 1'b0;
    #1;
    chk("t6.async.valid",  32'(instr_valid),  0);
    chk("t6.async.addr",   32'(rom_address),  0);
    chk("t6.async.opcode", 32'(instr_opcode), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    chk_issue("t6.i0", 8'h86, 8'hAA, 1'b1, 1'b0, 7'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
